// File: rtl/sort_pkg.sv
// -----------------------------------------------------------------------------
// sort_pkg
// Shared helpers for the odd-even transposition sorting network.
//   CMP_W       : width that compare operands are extended to before the
//                 compare; elements must be strictly narrower than this.
//   stage_base  : first "lo" index of the pairs formed in a given stage
//                 (0 for even stages, 1 for odd stages).
//   cmp_swap    : swap decision for one (lo,hi) pair.
// -----------------------------------------------------------------------------
package sort_pkg;

  localparam int unsigned CMP_W = 64;

  function automatic int unsigned stage_base(input int unsigned stage);
    return stage % 2;
  endfunction

  // Operands arrive already sign- or zero-extended to CMP_W, so a single
  // full-width compare serves both modes. Equal keys never swap.
  function automatic logic cmp_swap(input logic [CMP_W-1:0] a,
                                    input logic [CMP_W-1:0] b,
                                    input logic             desc,
                                    input logic             signed_mode);
    logic a_gt_b;
    logic a_lt_b;
    if (signed_mode) begin
      a_gt_b = $signed(a) > $signed(b);
      a_lt_b = $signed(a) < $signed(b);
    end else begin
      a_gt_b = a > b;
      a_lt_b = a < b;
    end
    return desc ? a_lt_b : a_gt_b;
  endfunction

endpackage

// File: rtl/sort_cmp_swap_cell.sv
// -----------------------------------------------------------------------------
// sort_cmp_swap_cell
// Combinational compare-exchange of one element pair.
//   a_i, b_i : elements at the lower / higher index of the pair
//   desc_i   : 0 = ascending (smaller to lo), 1 = descending (larger to lo)
//   lo_o     : element for the lower index
//   hi_o     : element for the higher index
// Elements are only routed, never modified.
// -----------------------------------------------------------------------------
module sort_cmp_swap_cell
  import sort_pkg::*;
#(
  parameter int unsigned SIZE_DATA  = 8,
  parameter bit          SIGNED_CMP = 1'b0
) (
  input  logic [SIZE_DATA-1:0] a_i,
  input  logic [SIZE_DATA-1:0] b_i,
  input  logic                 desc_i,
  output logic [SIZE_DATA-1:0] lo_o,
  output logic [SIZE_DATA-1:0] hi_o
);

  localparam int unsigned PAD = CMP_W - SIZE_DATA;

  logic [CMP_W-1:0] a_ext;
  logic [CMP_W-1:0] b_ext;
  logic             swap;

  // Sign-extend in signed mode, zero-extend otherwise.
  assign a_ext = {{PAD{SIGNED_CMP & a_i[SIZE_DATA-1]}}, a_i};
  assign b_ext = {{PAD{SIGNED_CMP & b_i[SIZE_DATA-1]}}, b_i};
  assign swap  = cmp_swap(a_ext, b_ext, desc_i, SIGNED_CMP);

  assign lo_o = swap ? b_i : a_i;
  assign hi_o = swap ? a_i : b_i;

endmodule

// File: rtl/sort_net_pipe.sv
// -----------------------------------------------------------------------------
// sort_net_pipe
// NUM_ELEM-stage registered odd-even transposition sorting network, one
// vector per cycle, per-vector ascending/descending order, global stall.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_valid/o_ready: input handshake (o_ready = !o_valid | i_ready)
//   i_desc         : order flag of the input vector (1 = descending)
//   i_data         : input vector, element k at [k*SIZE_DATA +: SIZE_DATA]
//   o_valid/i_ready: output handshake
//   o_desc         : order flag travelling with the output vector
//   o_data         : sorted vector, same packing
// -----------------------------------------------------------------------------
module sort_net_pipe
  import sort_pkg::*;
#(
  parameter int unsigned SIZE_DATA  = 8,
  parameter int unsigned NUM_ELEM   = 4,
  parameter bit          SIGNED_CMP = 1'b0
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic                          i_desc,
  input  logic [NUM_ELEM*SIZE_DATA-1:0] i_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_desc,
  output logic [NUM_ELEM*SIZE_DATA-1:0] o_data
);

  typedef logic [NUM_ELEM-1:0][SIZE_DATA-1:0] vec_t;

  vec_t                stage_in [NUM_ELEM];
  vec_t                data_d   [NUM_ELEM];
  vec_t                data_q   [NUM_ELEM];
  logic [NUM_ELEM-1:0] valid_d;
  logic [NUM_ELEM-1:0] valid_q;
  logic [NUM_ELEM-1:0] desc_d;
  logic [NUM_ELEM-1:0] desc_q;
  logic                en;

  // A full output slot that downstream refuses freezes the whole pipe.
  assign en      = !o_valid | i_ready;
  assign o_ready = en;

  // Bit s of desc_d/valid_d is what stage s captures on an enabled edge.
  assign valid_d = {valid_q[NUM_ELEM-2:0], i_valid};
  assign desc_d  = {desc_q[NUM_ELEM-2:0], i_desc};

  for (genvar s = 0; s < NUM_ELEM; s++) begin : g_stage
    localparam int BASE = int'(stage_base(s));

    if (s == 0) begin : g_first
      assign stage_in[s] = i_data;
    end else begin : g_next
      assign stage_in[s] = data_q[s-1];
    end

    for (genvar k = 0; k < NUM_ELEM; k++) begin : g_elem
      localparam bit IS_LO = (k >= BASE) && (((k - BASE) % 2) == 0) &&
                             (k + 1 < NUM_ELEM);
      localparam bit IS_HI = (k >= BASE + 1) && (((k - 1 - BASE) % 2) == 0);

      if (IS_LO) begin : g_pair
        sort_cmp_swap_cell #(
          .SIZE_DATA (SIZE_DATA),
          .SIGNED_CMP(SIGNED_CMP)
        ) u_cell (
          .a_i   (stage_in[s][k]),
          .b_i   (stage_in[s][k+1]),
          .desc_i(desc_d[s]),
          .lo_o  (data_d[s][k]),
          .hi_o  (data_d[s][k+1])
        );
      end else if (!IS_HI) begin : g_pass
        // Unpaired element in this stage: carried through unchanged.
        assign data_d[s][k] = stage_in[s][k];
      end
    end
  end

  // Stage registers: all stages shift together when enabled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= '0;
      desc_q  <= '0;
      for (int s = 0; s < NUM_ELEM; s++) data_q[s] <= '0;
    end else if (en) begin
      valid_q <= valid_d;
      desc_q  <= desc_d;
      for (int s = 0; s < NUM_ELEM; s++) data_q[s] <= data_d[s];
    end
  end

  assign o_valid = valid_q[NUM_ELEM-1];
  assign o_desc  = desc_q[NUM_ELEM-1];
  assign o_data  = data_q[NUM_ELEM-1];

endmodule

// File: tb/tb_sort_net_pipe.sv
module tb_sort_net_pipe;

  localparam int W = 8;
  localparam int N = 4;
  typedef logic [N*W-1:0] vec_t;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_valid = 1'b0;
  logic i_desc  = 1'b0;
  logic i_ready = 1'b1;
  vec_t i_data  = '0;

  logic o_ready_u, o_valid_u, o_desc_u;
  vec_t o_data_u;
  logic o_ready_s, o_valid_s, o_desc_s;
  vec_t o_data_s;

  int   total = 0;
  int   bad   = 0;
  int   rdy_mode = 0;  // 0: ready high, 1: ready low, 2: random
  vec_t exp_u_q[$];
  vec_t exp_s_q[$];
  bit   exp_d_q[$];

  always #5 i_clk = ~i_clk;

  sort_net_pipe #(.SIZE_DATA(W), .NUM_ELEM(N), .SIGNED_CMP(1'b0)) dut_u (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready_u),
    .i_desc(i_desc), .i_data(i_data), .o_valid(o_valid_u), .i_ready(i_ready),
    .o_desc(o_desc_u), .o_data(o_data_u));

  sort_net_pipe #(.SIZE_DATA(W), .NUM_ELEM(N), .SIGNED_CMP(1'b1)) dut_s (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready_s),
    .i_desc(i_desc), .i_data(i_data), .o_valid(o_valid_s), .i_ready(i_ready),
    .o_desc(o_desc_s), .o_data(o_data_s));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: stable insertion sort on integer keys.
  function automatic vec_t ref_sort(input vec_t v, input bit desc, input bit sgn);
    logic [W-1:0] e[N];
    int           key[N];
    logic [W-1:0] te;
    int           tk;
    vec_t         r;
    for (int k = 0; k < N; k++) begin
      e[k]   = v[k*W +: W];
      key[k] = sgn ? int'($signed(e[k])) : int'(e[k]);
    end
    for (int i = 1; i < N; i++) begin
      for (int j = i; j > 0; j--) begin
        if (desc ? (key[j-1] < key[j]) : (key[j-1] > key[j])) begin
          te = e[j-1]; e[j-1] = e[j]; e[j] = te;
          tk = key[j-1]; key[j-1] = key[j]; key[j] = tk;
        end else begin
          break;
        end
      end
    end
    r = '0;
    for (int k = 0; k < N; k++) r[k*W +: W] = e[k];
    return r;
  endfunction

  // Downstream ready driver (sole writer of i_ready).
  always @(posedge i_clk) begin
    #1;
    case (rdy_mode)
      0:       i_ready = 1'b1;
      1:       i_ready = 1'b0;
      default: i_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Stimulus side of the scoreboard: a transfer happens at the next edge.
  always @(negedge i_clk) begin
    if (i_rst_n && i_valid && o_ready_u) begin
      exp_u_q.push_back(ref_sort(i_data, i_desc, 1'b0));
      exp_s_q.push_back(ref_sort(i_data, i_desc, 1'b1));
      exp_d_q.push_back(i_desc);
    end
  end

  // Output monitor.
  always @(negedge i_clk) begin
    if (i_rst_n && o_valid_u && i_ready) begin
      if (exp_u_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got %0h want none", o_data_u);
      end else begin
        chk("data_unsigned", o_data_u, exp_u_q.pop_front());
        chk("data_signed", o_data_s, exp_s_q.pop_front());
        chk("valid_signed", o_valid_s, 1'b1);
        chk("desc_out", o_desc_u, exp_d_q[0]);
        chk("desc_signed", o_desc_s, exp_d_q.pop_front());
      end
    end
  end

  task automatic send(input vec_t d, input bit desc);
    int n;
    i_valid = 1'b1;
    i_data  = d;
    i_desc  = desc;
    n = 0;
    @(negedge i_clk);
    while (!o_ready_u && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_ready_u) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got o_ready=0 want 1");
    end
    @(posedge i_clk);
    #2;
    i_valid = 1'b0;
    i_data  = vec_t'($urandom);
    i_desc  = 1'($urandom);
  endtask

  task automatic idle(input int c);
    repeat (c) begin
      @(posedge i_clk);
      #2;
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    @(negedge i_clk);
    while (!o_valid_u && lat < 50) begin
      @(negedge i_clk);
      lat++;
    end
    if (!o_valid_u) begin
      total++;
      bad++;
      $display("FAIL wait_valid_timeout: got o_valid=0 want 1");
    end
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    v = vec_t'($urandom);
    if ($urandom_range(0, 1) == 1) v = v & 32'h03030303;  // force ties
    return v;
  endfunction

  initial begin
    int   lat;
    int   n;
    vec_t snap_d;
    logic snap_desc;

    // Reset state
    repeat (3) @(posedge i_clk);
    #2;
    chk("rst_valid", o_valid_u, 1'b0);
    chk("rst_data", o_data_u, '0);
    chk("rst_desc", o_desc_u, 1'b0);
    i_rst_n = 1'b1;
    #1;
    chk("rst_ready", o_ready_u, 1'b1);
    @(posedge i_clk);
    #2;

    // Ascending 3,1,4,1 with latency
    send(32'h01040103, 1'b0);
    wait_valid(lat);
    chk("latency", lat, N - 1);
    chk("asc_3141", o_data_u, 32'h04030101);
    chk("asc_desc_flag", o_desc_u, 1'b0);
    @(posedge i_clk); #2;

    // Signed descending, then unsigned ascending, of 0x80,0x7F,0x00,0xFF
    send(32'hFF007F80, 1'b1);
    wait_valid(lat);
    chk("signed_desc", o_data_s, 32'h80FF007F);
    chk("signed_desc_flag", o_desc_s, 1'b1);
    @(posedge i_clk); #2;
    send(32'hFF007F80, 1'b0);
    wait_valid(lat);
    chk("unsigned_asc", o_data_u, 32'hFF807F00);
    @(posedge i_clk); #2;

    // Back-to-back, alternating order; reverse input and all-equal ties
    send(32'h00010203, 1'b0);
    send(32'h05050505, 1'b1);
    send(32'h00010203, 1'b1);
    wait_valid(lat);
    chk("b2b_rev_asc", o_data_u, 32'h03020100);
    @(negedge i_clk);
    chk("b2b_valid1", o_valid_u, 1'b1);
    chk("b2b_ties", o_data_u, 32'h05050505);
    @(negedge i_clk);
    chk("b2b_valid2", o_valid_u, 1'b1);
    chk("b2b_rev_desc", o_data_u, 32'h00010203);
    chk("b2b_desc_flag", o_desc_u, 1'b1);
    @(posedge i_clk); #2;

    // Backpressure: fill, then stall 5 cycles with a pending input
    rdy_mode = 1;
    idle(1);
    for (int i = 0; i < N; i++) send(rand_vec(), 1'($urandom));
    i_valid = 1'b1;
    i_data  = rand_vec();
    i_desc  = 1'($urandom);
    @(negedge i_clk);
    chk("bp_full", o_valid_u, 1'b1);
    snap_d    = o_data_u;
    snap_desc = o_desc_u;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      chk("bp_ready", o_ready_u, 1'b0);
      chk("bp_ready_signed", o_ready_s, 1'b0);
      chk("bp_valid_hold", o_valid_u, 1'b1);
      chk("bp_data_hold", o_data_u, snap_d);
      chk("bp_desc_hold", o_desc_u, snap_desc);
    end
    rdy_mode = 0;
    send(i_data, i_desc);
    idle(2 * N);
    chk("bp_drained", exp_u_q.size(), 0);

    // Asynchronous reset with a full pipeline
    rdy_mode = 1;
    idle(1);
    for (int i = 0; i < N; i++) send(rand_vec(), 1'($urandom));
    #1;
    chk("pre_rst_valid", o_valid_u, 1'b1);
    i_rst_n = 1'b0;
    #1;
    chk("async_rst_valid", o_valid_u, 1'b0);
    chk("async_rst_data", o_data_u, '0);
    chk("async_rst_desc", o_desc_u, 1'b0);
    exp_u_q.delete();
    exp_s_q.delete();
    exp_d_q.delete();
    rdy_mode = 0;
    idle(2);
    i_rst_n = 1'b1;
    #1;
    chk("post_rst_ready", o_ready_u, 1'b1);
    for (int i = 0; i < N + 2; i++) begin
      @(negedge i_clk);
      chk("no_stale", o_valid_u, 1'b0);
    end
    @(posedge i_clk); #2;

    // Random traffic with random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else send(rand_vec(), 1'($urandom));
    end
    rdy_mode = 0;
    n = 0;
    while (exp_u_q.size() != 0 && n < 200) begin
      @(posedge i_clk);
      n++;
    end
    idle(2);
    chk("final_drain", exp_u_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sort_net_pipe.md
Name: sort_net_pipe

Overview:
- Parametrised N-element sorting network built from registered compare-exchange stages (odd-even transposition).
- One vector per cycle of throughput. Each vector carries its own ascending/descending flag. Signed or unsigned comparison is selected at elaboration.
- Valid/ready handshake on both sides, with global stall on backpressure.
- Sits in Core-Sort as the generalised successor of the single two-input registered compare cell. Feeds downstream merge/select logic.

Parameters:
- SIZE_DATA, 8, element width in bits (>=1)
- NUM_ELEM, 4, elements per vector (>=2). Pipeline depth equals NUM_ELEM.
- SIGNED_CMP, 0, 1 = two's-complement compare, 0 = unsigned compare

Ports:
- i_clk  in  1  clock; reset i_rst_n, asynchronous, active-low
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  input vector valid
- o_ready  out  1  block can accept input this cycle
- i_desc  in  1  per-vector order: 0 = ascending, 1 = descending
- i_data  in  NUM_ELEM*SIZE_DATA  input vector; element k at [k*SIZE_DATA +: SIZE_DATA]
- o_valid  out  1  output vector valid
- i_ready  in  1  downstream accepts output
- o_desc  out  1  order flag travelling with the output vector
- o_data  out  NUM_ELEM*SIZE_DATA  sorted vector, same packing

Behaviour:
- Pipeline of NUM_ELEM register stages, s = 0..NUM_ELEM-1. Each stage registers data[], desc and valid.
- Stage s pairing:
  - s even: pairs (0,1),(2,3),...
  - s odd: pairs (1,2),(3,4),...
  - An unpaired element passes through registered, unchanged.
- Compare-exchange for pair (lo,hi):
  - ascending: swap iff elem[lo] > elem[hi]
  - descending: swap iff elem[lo] < elem[hi]
  - Ties never swap, so equal keys keep input order.
- Compare uses $signed when SIGNED_CMP=1, otherwise unsigned. No width growth; elements are moved, never modified.
- Ascending result: element 0 holds the minimum. Descending result: element 0 holds the maximum.
- Global enable: en = !o_valid | i_ready. o_ready = en, combinational.
- When en=1:
  - all stages shift; stage 0 captures i_data/i_desc/i_valid.
  - Stage registers may load data even when valid=0; only valid bits are observable.
- When en=0: all stage registers hold.
- Latency: a vector accepted at edge t (i_valid & o_ready) appears on o_valid/o_data after NUM_ELEM enabled edges, i.e. cycle t+NUM_ELEM with no stalls.
- Throughput: 1 vector/cycle. No bubble collapsing; bubbles travel with the pipeline.
- o_data/o_desc are stable while o_valid=1 and i_ready=0.
- Simultaneous events: i_valid with i_ready=0 and o_valid=1 → input not accepted (o_ready=0). Upstream must hold i_data/i_desc.
- Reset (async, any time, including mid-stream):
  - all valid bits, data, and desc registers go to 0
  - o_valid=0, o_data=0, o_desc=0
  - o_ready=1 once reset releases
  - in-flight vectors are discarded
- X on i_data while i_valid=0 must never propagate to o_valid.

Decomposition:
- Package sort_pkg:
  - function cmp_swap(a, b, desc, signed_mode) returning the swap decision
  - localparam helper for stage parity
- Sub-module sort_cmp_swap_cell: combinational pair compare-exchange, parameters SIZE_DATA and SIGNED_CMP, inputs a, b, desc, outputs lo, hi.
- The top level generates NUM_ELEM stages × pair cells plus stage registers and valid/desc pipeline.

Test Plan:
- Asc sort (W=8, N=4, unsigned): elems 0..3 = 3,1,4,1, i_desc=0, i_ready=1 → after 4 cycles o_valid=1 with 1,1,3,4 and o_desc=0.
- Desc + signed (SIGNED_CMP=1): elems 0x80,0x7F,0x00,0xFF (-128,127,0,-1), i_desc=1 → 0x7F,0x00,0xFF,0x80. Same input with SIGNED_CMP=0 and i_desc=0 → 0x00,0x7F,0x80,0xFF.
- Back-to-back with mixed modes: 3 consecutive vectors alternating i_desc → 3 consecutive o_valid cycles, each correctly ordered for its own flag, o_desc matching.
- Backpressure:
  - pipeline full, hold i_ready=0 for 5 cycles → o_ready=0, o_data/o_valid/o_desc constant.
  - release i_ready → outputs drain in order, no loss or duplication.
- Reset mid-stream: assert i_rst_n=0 with 2 vectors in flight → o_valid=0, o_data=0 immediately (async). After release, no stale vector ever emerges.
- Worst case and ties: N=8 reverse-ordered 7..0 ascending → 0..7. All-equal input 5,5,...,5 → identical output, no swaps.
